// File: rtl/ic_fetch.sv
// Instruction-fetch stage: owns the PC, issues one SRAM read at a time and
// presents each fetched instruction to decode as a registered slot.
module ic_fetch #(
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000,
    parameter int          ADEL_BIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        br_e,
    input  logic [31:0] br_addr,
    output logic        stallreq,
    output logic        inst_sram_req,
    output logic [31:0] inst_sram_addr,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,
    output logic [64:0] ic_to_id_bus,
    output logic [31:0] ic_inst
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_stateNext;
    logic [31:0] r_pc;
    logic [31:0] r_addr;
    logic [31:0] r_icPc;
    logic [31:0] r_icInst;
    logic [31:0] r_excepttype;
    logic        r_cancel;
    logic        r_slotValid;

    logic        w_hold;
    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_misaligned;
    logic        w_issue;
    logic        w_dataIn;
    logic        w_fill;
    logic        w_fault;
    logic        w_consume;
    logic [31:0] w_pcNext;
    logic        w_unusedStall;

    assign w_unusedStall = ^{stall[5:2], stall[0]};

    // r_addr equals r_pc unless a redirect hit a request still waiting for
    // addr_ok; that request keeps its original address until accepted.
    assign w_hold       = stall[1];
    assign w_redirect   = flush | (br_e & ~w_hold);
    assign w_target     = flush ? new_pc : br_addr;
    assign w_misaligned = (r_addr[1:0] != 2'b00);
    assign w_issue      = (r_state == ST_REQ) & ~w_misaligned;
    assign w_dataIn     = (r_state == ST_WAIT) & inst_sram_data_ok;
    assign w_fill       = w_dataIn & ~r_cancel & ~w_redirect;
    assign w_fault      = (r_state == ST_REQ) & w_misaligned & ~w_redirect;
    assign w_consume    = (r_state == ST_FULL) & ~w_hold;
    assign w_pcNext     = w_redirect ? w_target : (w_consume ? r_pc + 32'd4 : r_pc);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_REQ;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        unique case (r_state)
            ST_REQ: begin
                if (w_misaligned) begin
                    w_stateNext = w_redirect ? ST_REQ : ST_FULL;
                end else if (inst_sram_addr_ok) begin
                    w_stateNext = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (inst_sram_data_ok) begin
                    w_stateNext = (r_cancel | w_redirect) ? ST_REQ : ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_redirect | ~w_hold) begin
                    w_stateNext = ST_REQ;
                end
            end
            default: w_stateNext = ST_REQ;
        endcase
    end

    always_comb begin
        inst_sram_req  = rst & w_issue;
        inst_sram_addr = r_addr;
        stallreq       = rst & ~r_slotValid & ~flush & ~br_e;
        ic_to_id_bus   = {r_excepttype, r_slotValid, r_icPc};
        ic_inst        = r_icInst;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc         <= RESET_PC;
            r_addr       <= RESET_PC;
            r_cancel     <= 1'b0;
            r_slotValid  <= 1'b0;
            r_icPc       <= 32'd0;
            r_icInst     <= 32'd0;
            r_excepttype <= 32'd0;
        end else begin
            r_pc <= w_pcNext;
            if ((w_stateNext == ST_REQ) && !w_issue) begin
                r_addr <= w_pcNext;
            end
            if (w_dataIn) begin
                r_cancel <= 1'b0;
            end else if (w_redirect && (w_issue || (r_state == ST_WAIT))) begin
                r_cancel <= 1'b1;
            end
            r_slotValid <= w_fill | w_fault | ((r_state == ST_FULL) & w_hold & ~w_redirect);
            if (w_fill) begin
                r_icInst     <= inst_sram_rdata;
                r_icPc       <= r_pc;
                r_excepttype <= 32'd0;
            end else if (w_fault) begin
                r_icInst     <= 32'd0;
                r_icPc       <= r_pc;
                r_excepttype <= 32'd1 << ADEL_BIT;
            end else if (w_redirect) begin
                r_excepttype <= 32'd0;
            end
        end
    end

endmodule
